// File: rtl/block_average_downscaler.sv
// block_average_downscaler
// Averages non-overlapping FxF blocks (F = 2 or 4, chosen per frame) of a
// raster-order pixel stream and emits one rounded-to-nearest pixel per block.
// Pixels that fall in partial blocks at the right or bottom edge are consumed
// and discarded.
//
// Ports:
//   clk, resetn             clock (rising edge), async active-low reset
//   start                   one-cycle frame start, honoured only when idle
//   factor_sel              0 = 2x2 blocks, 1 = 4x4 blocks (sampled with start)
//   width_in, height_in     input frame dimensions (sampled with start)
//   in_valid/in_ready       input pixel handshake, in_pixel raster order
//   out_valid/out_ready     output pixel handshake, out_pixel averaged value
//   out_width, out_height   output frame dimensions, registered at start
//   busy                    high while a frame is in progress (RUN or DRAIN)
//   done                    one-cycle pulse when the frame is finished
//   cfg_error               one-cycle pulse when a start is rejected
module block_average_downscaler #(
    parameter int PIXEL_W   = 8,
    parameter int MAX_WIDTH = 640,
    parameter int DIM_W     = 10
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               factor_sel,
    input  logic [DIM_W-1:0]   width_in,
    input  logic [DIM_W-1:0]   height_in,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PIXEL_W-1:0] in_pixel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PIXEL_W-1:0] out_pixel,
    output logic [DIM_W-1:0]   out_width,
    output logic [DIM_W-1:0]   out_height,
    output logic               busy,
    output logic               done,
    output logic               cfg_error
);

    localparam int HS_W  = PIXEL_W + 2;   // one block row: up to 4 pixels
    localparam int ACC_W = PIXEL_W + 4;   // up to 3 block rows of 4 pixels
    localparam int SUM_W = PIXEL_W + 5;   // full block plus rounding term
    localparam int DEPTH = MAX_WIDTH / 2;
    localparam int COL_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_n;
    logic                 f4_r;
    logic [DIM_W-1:0]     width_r;
    logic [DIM_W-1:0]     height_r;
    logic [DIM_W-1:0]     out_width_r;
    logic [DIM_W-1:0]     out_height_r;
    logic [DIM_W-1:0]     x_r;
    logic [DIM_W-1:0]     y_r;
    logic [HS_W-1:0]      h_sum_r;
    logic                 out_valid_r;
    logic [PIXEL_W-1:0]   out_pixel_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 cfg_error_r;
    logic [ACC_W-1:0]     col_mem [0:DEPTH-1];

    logic                 in_ready_s;
    logic                 fire_s;
    logic [DIM_W-1:0]     f_in_s;
    logic                 cfg_bad_s;
    logic                 accept_s;
    logic                 done_s;
    logic                 cfg_err_s;
    logic [1:0]           fm1_s;
    logic [1:0]           xf_s;
    logic [1:0]           yf_s;
    logic [DIM_W-1:0]     col_full_s;
    logic [DIM_W-1:0]     row_full_s;
    logic [COL_W-1:0]     col_idx_s;
    logic                 in_region_s;
    logic                 col_end_s;
    logic                 load_s;
    logic                 wr_en_s;
    logic [ACC_W-1:0]     wr_data_s;
    logic [ACC_W-1:0]     entry_s;
    logic [HS_W-1:0]      cur_sum_s;
    logic [ACC_W-1:0]     acc_sum_s;
    logic [SUM_W-1:0]     total_s;
    logic [SUM_W-1:0]     shifted_s;
    logic [PIXEL_W-1:0]   avg_s;
    logic                 last_x_s;
    logic                 last_y_s;
    logic                 last_pix_s;
    logic                 unused_s;

    // Handshake, block position and arithmetic for the pixel currently offered
    always_comb begin
        in_ready_s  = (state_r == RUN) && (!out_valid_r || out_ready);
        fire_s      = in_valid && in_ready_s;
        f_in_s      = factor_sel ? DIM_W'(4) : DIM_W'(2);
        cfg_bad_s   = (width_in > DIM_W'(MAX_WIDTH)) || (width_in < f_in_s) || (height_in < f_in_s);
        fm1_s       = f4_r ? 2'd3 : 2'd1;
        xf_s        = f4_r ? x_r[1:0] : {1'b0, x_r[0]};
        yf_s        = f4_r ? y_r[1:0] : {1'b0, y_r[0]};
        col_full_s  = f4_r ? (x_r >> 2) : (x_r >> 1);
        row_full_s  = f4_r ? (y_r >> 2) : (y_r >> 1);
        col_idx_s   = col_full_s[COL_W-1:0];
        // Columns/rows beyond the last whole block are consumed but ignored
        in_region_s = (col_full_s < out_width_r) && (row_full_s < out_height_r);
        col_end_s   = fire_s && in_region_s && (xf_s == fm1_s);
        entry_s     = col_mem[col_idx_s];
        cur_sum_s   = (xf_s == 2'd0) ? HS_W'(in_pixel) : (h_sum_r + HS_W'(in_pixel));
        acc_sum_s   = entry_s + ACC_W'(cur_sum_s);
        // Add half the divisor before shifting for round-to-nearest
        total_s     = SUM_W'(entry_s) + SUM_W'(cur_sum_s) + (f4_r ? SUM_W'(8) : SUM_W'(2));
        shifted_s   = f4_r ? (total_s >> 4) : (total_s >> 2);
        avg_s       = shifted_s[PIXEL_W-1:0];
        unused_s    = ^shifted_s[SUM_W-1:PIXEL_W];
        load_s      = col_end_s && (yf_s == fm1_s);
        wr_en_s     = col_end_s && (yf_s != fm1_s);
        // The first row of a block overwrites, so stale entries never leak
        wr_data_s   = (yf_s == 2'd0) ? ACC_W'(cur_sum_s) : acc_sum_s;
        last_x_s    = (x_r == width_r - DIM_W'(1));
        last_y_s    = (y_r == height_r - DIM_W'(1));
        last_pix_s  = fire_s && last_x_s && last_y_s;
    end

    // Next-state logic and frame-level pulses
    always_comb begin
        state_n   = state_r;
        accept_s  = 1'b0;
        done_s    = 1'b0;
        cfg_err_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (cfg_bad_s) begin
                        cfg_err_s = 1'b1;
                    end else begin
                        accept_s = 1'b1;
                        state_n  = RUN;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            RUN: begin
                if (last_pix_s) begin
                    // A result still to be delivered holds done back until it transfers
                    if (load_s || (out_valid_r && !out_ready)) begin
                        state_n = DRAIN;
                    end else begin
                        state_n = IDLE;
                        done_s  = 1'b1;
                    end
                end else begin
                    state_n = RUN;
                end
            end
            DRAIN: begin
                if (!out_valid_r || out_ready) begin
                    state_n = IDLE;
                    done_s  = 1'b1;
                end else begin
                    state_n = DRAIN;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State register and registered status outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            cfg_error_r <= 1'b0;
        end else begin
            state_r     <= state_n;
            busy_r      <= (state_n != IDLE);
            done_r      <= done_s;
            cfg_error_r <= cfg_err_s;
        end
    end

    // Frame configuration, raster counters and horizontal block-row sum
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            f4_r         <= 1'b0;
            width_r      <= {DIM_W{1'b0}};
            height_r     <= {DIM_W{1'b0}};
            out_width_r  <= {DIM_W{1'b0}};
            out_height_r <= {DIM_W{1'b0}};
            x_r          <= {DIM_W{1'b0}};
            y_r          <= {DIM_W{1'b0}};
            h_sum_r      <= {HS_W{1'b0}};
        end else if (accept_s) begin
            f4_r         <= factor_sel;
            width_r      <= width_in;
            height_r     <= height_in;
            out_width_r  <= factor_sel ? (width_in >> 2) : (width_in >> 1);
            out_height_r <= factor_sel ? (height_in >> 2) : (height_in >> 1);
            x_r          <= {DIM_W{1'b0}};
            y_r          <= {DIM_W{1'b0}};
            h_sum_r      <= {HS_W{1'b0}};
        end else if (fire_s) begin
            h_sum_r <= cur_sum_s;
            if (last_x_s) begin
                x_r <= {DIM_W{1'b0}};
                y_r <= y_r + DIM_W'(1);
            end else begin
                x_r <= x_r + DIM_W'(1);
            end
        end
    end

    // Output register: holds a result until taken, may reload in the same cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid_r <= 1'b0;
            out_pixel_r <= {PIXEL_W{1'b0}};
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            out_pixel_r <= avg_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    // Per-column partial block sums; contents need no reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            col_mem[col_idx_s] <= wr_data_s;
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_r;
    assign out_pixel  = out_pixel_r;
    assign out_width  = out_width_r;
    assign out_height = out_height_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign cfg_error  = cfg_error_r;

endmodule

// File: tb/tb_block_average_downscaler.sv
module tb_block_average_downscaler;

    localparam int PW = 8;
    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic          factor_sel = 1'b0;
    logic [DW-1:0] width_in = '0;
    logic [DW-1:0] height_in = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [PW-1:0] in_pixel = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [PW-1:0] out_pixel;
    logic [DW-1:0] out_width;
    logic [DW-1:0] out_height;
    logic          busy;
    logic          done;
    logic          cfg_error;

    block_average_downscaler #(.PIXEL_W(PW), .MAX_WIDTH(640), .DIM_W(DW)) dut (
        .clk(clk), .resetn(resetn), .start(start), .factor_sel(factor_sel),
        .width_in(width_in), .height_in(height_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
        .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
        .out_width(out_width), .out_height(out_height),
        .busy(busy), .done(done), .cfg_error(cfg_error)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] frame [0:255];
    string tname = "init";
    int got_n = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_xfer_cyc = 0;
    int last_in_cyc = 0;
    int in_xfer_cnt = 0;
    int stab_err = 0;
    int ir_err = 0;
    int both_err = 0;
    bit rand_mode = 1'b0;
    int stall_idx = -1;
    int stall_len = 0;
    bit hold_prev = 1'b0;
    logic [PW-1:0] prev_pix = '0;

    always @(posedge clk) cyc++;

    // Scoreboard and protocol monitor, sampled on the falling edge
    always @(negedge clk) begin
        logic [PW-1:0] e;
        if (out_valid && out_ready) begin
            got_n++;
            last_xfer_cyc = cyc;
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_extra[%s] got %0d expected no output", tname, out_pixel);
            end else begin
                e = exp_q.pop_front();
                if (out_pixel !== e) $display("FAIL sb_pixel[%s] got %0d expected %0d", tname, out_pixel, e);
                else pass_cnt++;
            end
        end
        if (in_valid && in_ready) in_xfer_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (done && cfg_error) both_err++;
        if (hold_prev && (!out_valid || out_pixel !== prev_pix)) stab_err++;
        if (out_valid && !out_ready && in_ready) ir_err++;
        hold_prev = resetn && out_valid && !out_ready;
        prev_pix  = out_pixel;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (stall_len > 0 && out_valid && got_n == stall_idx) begin
            out_ready = 1'b0;
            stall_len--;
        end else if (rand_mode) begin
            out_ready = ($urandom_range(0, 2) != 0);
        end else begin
            out_ready = 1'b1;
        end
    endtask

    // Reference block averages of frame[], pushed as expected outputs
    task automatic push_model(input bit fsel, input int w, input int h);
        int f;
        int s;
        f = fsel ? 4 : 2;
        for (int by = 0; by < h / f; by++) begin
            for (int bx = 0; bx < w / f; bx++) begin
                s = 0;
                for (int dy = 0; dy < f; dy++)
                    for (int dx = 0; dx < f; dx++)
                        s += int'(frame[(by * f + dy) * w + bx * f + dx]);
                s = (s + f * f / 2) / (f * f);
                exp_q.push_back(s[PW-1:0]);
            end
        end
    endtask

    task automatic drive_frame(input bit fsel, input int w, input int h);
        int n;
        int d0;
        got_n = 0;
        in_xfer_cnt = 0;
        d0 = done_cnt;
        factor_sel = fsel;
        width_in = w[DW-1:0];
        height_in = h[DW-1:0];
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < w * h; i++) begin
            if (rand_mode && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            in_pixel = frame[i];
            n = 0;
            forever begin
                @(negedge clk);
                if (in_ready || n >= 300) break;
                tick();
                n++;
            end
            if (n >= 300) begin
                total_cnt++;
                $display("FAIL in_ready_timeout[%s] got pixel %0d stuck expected acceptance", tname, i);
                in_valid = 1'b0;
                return;
            end
            tick();
            last_in_cyc = cyc;
        end
        in_valid = 1'b0;
        n = 0;
        forever begin
            @(negedge clk);
            #1;
            if (done_cnt != d0 || n >= 300) break;
            tick();
            n++;
        end
        if (n >= 300) begin
            total_cnt++;
            $display("FAIL done_timeout[%s] got no done expected done pulse", tname);
        end
    endtask

    task automatic test_reset();
        tname = "reset";
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({out_valid, busy, done, cfg_error, in_ready} !== 5'b0)
            $display("FAIL reset_flags got %b expected 00000", {out_valid, busy, done, cfg_error, in_ready});
        else pass_cnt++;
        total_cnt++;
        if ({out_pixel, out_width, out_height} !== '0)
            $display("FAIL reset_values got %0d/%0d/%0d expected 0/0/0", out_pixel, out_width, out_height);
        else pass_cnt++;
    endtask

    task automatic test_basic_f2();
        tname = "basic_f2";
        for (int i = 0; i < 16; i++) frame[i] = i[PW-1:0];
        exp_q.push_back(8'd3);
        exp_q.push_back(8'd5);
        exp_q.push_back(8'd11);
        exp_q.push_back(8'd13);
        drive_frame(1'b0, 4, 4);
        total_cnt++;
        if (exp_q.size() !== 0) $display("FAIL basic_missing got %0d left expected 0", exp_q.size());
        else pass_cnt++;
        total_cnt++;
        if ({out_width, out_height} !== {10'd2, 10'd2})
            $display("FAIL basic_dims got %0dx%0d expected 2x2", out_width, out_height);
        else pass_cnt++;
        total_cnt++;
        if (done_cyc !== last_xfer_cyc + 1)
            $display("FAIL basic_done_timing got %0d expected %0d", done_cyc, last_xfer_cyc + 1);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL basic_busy_after got %0d expected 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_rounding();
        tname = "rounding";
        frame[0] = 8'd1; frame[1] = 8'd2; frame[2] = 8'd2; frame[3] = 8'd2;
        exp_q.push_back(8'd2);
        drive_frame(1'b0, 2, 2);
        for (int i = 0; i < 4; i++) frame[i] = 8'd255;
        exp_q.push_back(8'd255);
        drive_frame(1'b0, 2, 2);
        total_cnt++;
        if (exp_q.size() !== 0) $display("FAIL rounding_missing got %0d left expected 0", exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_f4();
        tname = "f4";
        for (int i = 0; i < 32; i++) frame[i] = 8'd10;
        frame[2 * 8 + 5] = 8'd26;
        exp_q.push_back(8'd10);
        exp_q.push_back(8'd11);   // (15*10 + 26 + 8) >> 4
        drive_frame(1'b1, 8, 4);
        total_cnt++;
        if ({out_width, out_height} !== {10'd2, 10'd1})
            $display("FAIL f4_dims got %0dx%0d expected 2x1", out_width, out_height);
        else pass_cnt++;
        for (int i = 0; i < 32; i++) frame[i] = 8'd255;
        exp_q.push_back(8'd255);
        exp_q.push_back(8'd255);
        drive_frame(1'b1, 8, 4);
        total_cnt++;
        if (exp_q.size() !== 0) $display("FAIL f4_missing got %0d left expected 0", exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_ragged();
        tname = "ragged";
        for (int i = 0; i < 15; i++) frame[i] = PW'($urandom_range(0, 255));
        push_model(1'b0, 5, 3);
        drive_frame(1'b0, 5, 3);
        total_cnt++;
        if ({out_width, out_height} !== {10'd2, 10'd1})
            $display("FAIL ragged_dims got %0dx%0d expected 2x1", out_width, out_height);
        else pass_cnt++;
        total_cnt++;
        if (in_xfer_cnt !== 15) $display("FAIL ragged_inputs got %0d expected 15", in_xfer_cnt);
        else pass_cnt++;
        total_cnt++;
        if (got_n !== 2 || exp_q.size() !== 0)
            $display("FAIL ragged_outputs got %0d expected 2", got_n);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        tname = "backpressure";
        for (int i = 0; i < 16; i++) frame[i] = PW'($urandom_range(0, 255));
        push_model(1'b0, 4, 4);
        stall_idx = 0;
        stall_len = 5;
        drive_frame(1'b0, 4, 4);
        total_cnt++;
        if (stall_len !== 0) $display("FAIL bp_stall_applied got %0d left expected 0", stall_len);
        else pass_cnt++;
        for (int i = 0; i < 16; i++) frame[i] = PW'($urandom_range(0, 255));
        push_model(1'b0, 4, 4);
        stall_idx = 3;
        stall_len = 4;
        drive_frame(1'b0, 4, 4);
        total_cnt++;
        if (last_xfer_cyc < last_in_cyc + 4)
            $display("FAIL bp_drain_stall got %0d expected >= %0d", last_xfer_cyc, last_in_cyc + 4);
        else pass_cnt++;
        total_cnt++;
        if (done_cyc !== last_xfer_cyc + 1)
            $display("FAIL bp_drain_done got %0d expected %0d", done_cyc, last_xfer_cyc + 1);
        else pass_cnt++;
        total_cnt++;
        if (exp_q.size() !== 0) $display("FAIL bp_missing got %0d left expected 0", exp_q.size());
        else pass_cnt++;
        total_cnt++;
        if ({stab_err, ir_err} !== {32'd0, 32'd0})
            $display("FAIL bp_protocol got %0d/%0d expected 0/0", stab_err, ir_err);
        else pass_cnt++;
        stall_idx = -1;
    endtask

    task automatic test_cfg_error();
        int d0;
        tname = "cfg_error";
        d0 = done_cnt;
        for (int k = 0; k < 2; k++) begin
            factor_sel = 1'b0;
            width_in = (k == 0) ? 10'd700 : 10'd4;
            height_in = (k == 0) ? 10'd4 : 10'd1;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            @(negedge clk);
            total_cnt++;
            if ({cfg_error, busy, in_ready} !== 3'b100)
                $display("FAIL cfg_pulse%0d got %b expected 100", k, {cfg_error, busy, in_ready});
            else pass_cnt++;
            @(negedge clk);
            total_cnt++;
            if ({cfg_error, busy, in_ready} !== 3'b000)
                $display("FAIL cfg_after%0d got %b expected 000", k, {cfg_error, busy, in_ready});
            else pass_cnt++;
        end
        total_cnt++;
        if (done_cnt !== d0) $display("FAIL cfg_no_done got %0d expected %0d", done_cnt, d0);
        else pass_cnt++;
    endtask

    task automatic test_reset_midframe();
        int d0;
        tname = "reset_mid";
        factor_sel = 1'b0;
        width_in = 10'd4;
        height_in = 10'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_pixel = 8'd200;
            tick();
        end
        in_valid = 1'b0;
        resetn = 1'b0;
        d0 = done_cnt;
        @(negedge clk);
        total_cnt++;
        if ({busy, in_ready, out_valid, done} !== 4'b0)
            $display("FAIL midreset_flags got %b expected 0000", {busy, in_ready, out_valid, done});
        else pass_cnt++;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        for (int i = 0; i < 16; i++) frame[i] = PW'($urandom_range(0, 60));
        push_model(1'b0, 4, 4);
        drive_frame(1'b0, 4, 4);
        total_cnt++;
        if (exp_q.size() !== 0) $display("FAIL midreset_missing got %0d left expected 0", exp_q.size());
        else pass_cnt++;
        total_cnt++;
        if (done_cnt !== d0 + 1) $display("FAIL midreset_done_count got %0d expected %0d", done_cnt, d0 + 1);
        else pass_cnt++;
    endtask

    task automatic test_random();
        tname = "random";
        rand_mode = 1'b1;
        for (int i = 0; i < 96; i++) frame[i] = PW'($urandom_range(0, 255));
        push_model(1'b1, 12, 8);
        drive_frame(1'b1, 12, 8);
        for (int i = 0; i < 35; i++) frame[i] = PW'($urandom_range(0, 255));
        push_model(1'b0, 7, 5);
        drive_frame(1'b0, 7, 5);
        rand_mode = 1'b0;
        total_cnt++;
        if (exp_q.size() !== 0) $display("FAIL random_missing got %0d left expected 0", exp_q.size());
        else pass_cnt++;
        total_cnt++;
        if ({stab_err, ir_err} !== {32'd0, 32'd0})
            $display("FAIL random_protocol got %0d/%0d expected 0/0", stab_err, ir_err);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic_f2();
        test_rounding();
        test_f4();
        test_ragged();
        test_backpressure();
        test_cfg_error();
        test_reset_midframe();
        test_random();
        total_cnt++;
        if (both_err !== 0) $display("FAIL done_with_cfg_error got %0d expected 0", both_err);
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
